// File: rtl/alu_acc_ctrl_if.sv
// Command, response, flag and downstream-ALU signals of the accumulator controller.
// The slave modport is the controller side; master is the requester/ALU side.
interface alu_acc_ctrl_if #(parameter int unsigned n = 4);
  logic         cmd_valid;
  logic         cmd_ready;
  logic         cmd_load;
  logic [2:0]   cmd_op;
  logic [n-1:0] cmd_data;

  logic [n-1:0] alu_A;
  logic [n-1:0] alu_B;
  logic [2:0]   alu_Mode;
  logic         alu_CB_in;
  logic [n-1:0] alu_Result;
  logic         alu_CB_out;

  logic         rsp_valid;
  logic         rsp_ready;
  logic [n-1:0] rsp_data;
  logic         flag_c;
  logic         flag_z;

  modport slave (
    input  cmd_valid, cmd_load, cmd_op, cmd_data, rsp_ready, alu_Result, alu_CB_out,
    output cmd_ready, rsp_valid, rsp_data, flag_c, flag_z,
           alu_A, alu_B, alu_Mode, alu_CB_in
  );

  modport master (
    output cmd_valid, cmd_load, cmd_op, cmd_data, rsp_ready, alu_Result, alu_CB_out,
    input  cmd_ready, rsp_valid, rsp_data, flag_c, flag_z,
           alu_A, alu_B, alu_Mode, alu_CB_in
  );
endinterface

// File: rtl/alu_acc_ctrl.sv
// Accumulator controller: accepts a load/ALU command, runs one EXEC cycle through an
// external combinational ALU, then presents the new accumulator until it is taken.
module alu_acc_ctrl #(
  parameter int unsigned n = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  alu_acc_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t       state;
  logic [n-1:0] acc;
  logic         lat_load;
  logic [n-1:0] new_acc;

  // alu_B and alu_Mode double as the latched command data and op.
  always_comb begin
    new_acc      = lat_load ? bus.alu_B : bus.alu_Result;
    bus.rsp_data = acc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      acc           <= '0;
      lat_load      <= 1'b0;
      bus.cmd_ready <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.flag_c    <= 1'b0;
      bus.flag_z    <= 1'b0;
      bus.alu_A     <= '0;
      bus.alu_B     <= '0;
      bus.alu_Mode  <= '0;
      bus.alu_CB_in <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.cmd_valid && bus.cmd_ready) begin
            lat_load      <= bus.cmd_load;
            bus.alu_A     <= acc;
            bus.alu_B     <= bus.cmd_data;
            bus.alu_Mode  <= bus.cmd_op;
            bus.alu_CB_in <= bus.flag_c;
            bus.cmd_ready <= 1'b0;
            state         <= EXEC;
          end else begin
            bus.cmd_ready <= 1'b1;
          end
        end
        EXEC: begin
          acc        <= new_acc;
          bus.flag_z <= (new_acc == '0);
          if (lat_load)
            bus.flag_c <= 1'b0;
          else if (bus.alu_Mode == 3'b000 || bus.alu_Mode == 3'b001)
            bus.flag_c <= bus.alu_CB_out;
          bus.rsp_valid <= 1'b1;
          state         <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            bus.cmd_ready <= 1'b1;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_acc_ctrl.sv
// Self-checking bench for alu_acc_ctrl (n=4): directed commands with literal expectations
// plus a transaction-level accumulator model checked every meaningful cycle.
module tb_alu_acc_ctrl;

  logic clk;
  logic rst_n;
  int   compared;
  int   mismatched;
  int   m_acc;
  int   m_c;
  int   m_z;

  alu_acc_ctrl_if #(.n(4)) bus ();

  alu_acc_ctrl #(.n(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference 4-bit ALU; non-arithmetic modes return the inverse of carry-in on CB_out
  // so that a controller wrongly capturing it would flip flag_c.
  function automatic logic [4:0] alu_fn(input int a, input int b, input int cin, input int mode);
    int r;
    int co;
    co = (cin == 0) ? 1 : 0;
    case (mode)
      0: begin r = a + b + cin; co = (r > 15) ? 1 : 0; end
      1: begin r = a - b;       co = (a < b) ? 1 : 0; end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = ~a;
      6: r = a + 1;
      default: r = a - 1;
    endcase
    return {co[0], r[3:0]};
  endfunction

  always_comb begin
    {bus.alu_CB_out, bus.alu_Result} = alu_fn(int'(bus.alu_A), int'(bus.alu_B),
                                              int'(bus.alu_CB_in), int'(bus.alu_Mode));
  end

  task automatic check(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_acc = 0; m_c = 0; m_z = 0;
  endtask

  task automatic model_apply(input int load, input int op, input int data);
    logic [4:0] r;
    if (load != 0) begin
      m_acc = data;
      m_c   = 0;
    end else begin
      r     = alu_fn(m_acc, data, m_c, op);
      m_acc = int'(r[3:0]);
      if (op <= 1) m_c = int'(r[4]);
    end
    m_z = (m_acc == 0) ? 1 : 0;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      check("excl_ready_valid", int'(bus.rsp_valid && bus.cmd_ready), 0);
      if (bus.rsp_valid || bus.cmd_ready) begin
        check("mdl_data", int'(bus.rsp_data), m_acc);
        check("mdl_c", int'(bus.flag_c), m_c);
        check("mdl_z", int'(bus.flag_z), m_z);
      end
    end
  end

  task automatic send(input string name, input int load, input int op, input int data,
                      input int exp_d, input int exp_c, input int exp_z, input int stall);
    int waited;
    int prev_acc;
    int prev_c;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b1;
    bus.cmd_load  = (load != 0);
    bus.cmd_op    = 3'(op);
    bus.cmd_data  = 4'(data);
    bus.rsp_ready = (stall == 0);
    waited = 0;
    forever begin
      @(negedge clk);
      if (bus.cmd_ready) break;
      waited++;
      if (waited > 20) begin
        check({name, "_accept_timeout"}, 0, 1);
        bus.cmd_valid = 1'b0;
        return;
      end
    end
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    prev_acc = m_acc;
    prev_c   = m_c;
    model_apply(load, op, data);
    @(negedge clk);
    check({name, "_exec_ready"}, int'(bus.cmd_ready), 0);
    check({name, "_exec_valid"}, int'(bus.rsp_valid), 0);
    check({name, "_alu_A"}, int'(bus.alu_A), prev_acc);
    check({name, "_alu_B"}, int'(bus.alu_B), data);
    check({name, "_alu_Mode"}, int'(bus.alu_Mode), op);
    check({name, "_alu_CB_in"}, int'(bus.alu_CB_in), prev_c);
    @(negedge clk);
    check({name, "_rsp_valid"}, int'(bus.rsp_valid), 1);
    check({name, "_rsp_data"}, int'(bus.rsp_data), exp_d);
    check({name, "_flag_c"}, int'(bus.flag_c), exp_c);
    check({name, "_flag_z"}, int'(bus.flag_z), exp_z);
    check({name, "_model_pin"}, m_acc, exp_d);
    if (stall > 0) begin
      for (int i = 0; i < stall; i++) begin
        @(posedge clk); #1;
        bus.cmd_valid = 1'b1;
        bus.cmd_load  = 1'b1;
        bus.cmd_data  = 4'(~data);
        @(negedge clk);
        check({name, "_stall_valid"}, int'(bus.rsp_valid), 1);
        check({name, "_stall_data"}, int'(bus.rsp_data), exp_d);
        check({name, "_stall_ready"}, int'(bus.cmd_ready), 0);
      end
      @(posedge clk); #1;
      bus.cmd_valid = 1'b0;
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      check({name, "_held_valid"}, int'(bus.rsp_valid), 1);
    end
    @(negedge clk);
    check({name, "_back_idle_ready"}, int'(bus.cmd_ready), 1);
    check({name, "_back_idle_valid"}, int'(bus.rsp_valid), 0);
  endtask

  task automatic reset_release();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rel_cmd_ready", int'(bus.cmd_ready), 1);
    check("rel_rsp_valid", int'(bus.rsp_valid), 0);
    check("rel_acc", int'(bus.rsp_data), 0);
    check("rel_flag_c", int'(bus.flag_c), 0);
    check("rel_flag_z", int'(bus.flag_z), 0);
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    model_reset();
    rst_n         = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_load  = 1'b0;
    bus.cmd_op    = '0;
    bus.cmd_data  = '0;
    bus.rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", int'(bus.cmd_ready), 0);
    check("rst_rsp_valid", int'(bus.rsp_valid), 0);
    check("rst_acc", int'(bus.rsp_data), 0);
    reset_release();

    //   name        load op data  exp_d c z stall
    send("ld_f",     1, 0, 4'hF, 4'hF, 0, 0, 0);
    send("add_1",    0, 0, 4'h1, 4'h0, 1, 1, 0);
    send("add_0",    0, 0, 4'h0, 4'h1, 0, 0, 0);
    send("ld_3",     1, 0, 4'h3, 4'h3, 0, 0, 0);
    send("sub_5",    0, 1, 4'h5, 4'hE, 1, 0, 0);
    send("and_0",    0, 2, 4'h0, 4'h0, 1, 1, 0);
    send("or_a",     0, 3, 4'hA, 4'hA, 1, 0, 0);
    send("xor_f",    0, 4, 4'hF, 4'h5, 1, 0, 0);
    send("not",      0, 5, 4'h0, 4'hA, 1, 0, 0);
    send("inc",      0, 6, 4'h0, 4'hB, 1, 0, 0);
    send("dec",      0, 7, 4'h0, 4'hA, 1, 0, 0);
    send("ld_0",     1, 0, 4'h0, 4'h0, 0, 1, 0);
    send("dec_wrap", 0, 7, 4'h0, 4'hF, 0, 0, 0);
    send("inc_wrap", 0, 6, 4'h0, 4'h0, 0, 1, 0);
    send("ld_9_stl", 1, 0, 4'h9, 4'h9, 0, 0, 3);
    send("add_7",    0, 0, 4'h7, 4'h0, 1, 1, 0);

    // Reset pulsed while a LOAD 0x7 is in EXEC.
    @(posedge clk); #1;
    bus.cmd_valid = 1'b1;
    bus.cmd_load  = 1'b1;
    bus.cmd_op    = '0;
    bus.cmd_data  = 4'h7;
    @(negedge clk);
    check("abort_pre_ready", int'(bus.cmd_ready), 1);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    check("abort_rsp_valid", int'(bus.rsp_valid), 0);
    check("abort_cmd_ready", int'(bus.cmd_ready), 0);
    check("abort_acc", int'(bus.rsp_data), 0);
    check("abort_flag_c", int'(bus.flag_c), 0);
    check("abort_alu_B", int'(bus.alu_B), 0);
    reset_release();
    send("post_add", 0, 0, 4'h2, 4'h2, 0, 0, 0);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_acc_ctrl.md
ALU_ACC_CTRL -- requirements
Module: alu_acc_ctrl

Interface
REQ-001 SHALL have parameter n, default 4, giving the data width of the accumulator, operands and ALU ports.
REQ-002 SHALL have port clk  input  1  as the single clock; all state SHALL update on its rising edge.
REQ-003 SHALL have port rst_n  input  1  as the reset, which is asynchronous and active-low.
REQ-004 SHALL have port cmd_valid  input  1  to signal that a command is present.
REQ-005 SHALL have port cmd_ready  output  1  to signal that the block can accept a command.
REQ-006 SHALL have port cmd_load  input  1  selecting the operation: 1 = load cmd_data into the accumulator, 0 = ALU operation.
REQ-007 SHALL have port cmd_op  input  3  carrying the ALU mode code (000 ADD+carry, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 NOT, 110 INC, 111 DEC).
REQ-008 SHALL have port cmd_data  input  n  carrying the B operand or the load value.
REQ-009 SHALL have ports alu_A, alu_B  output  n, alu_Mode  output  3 and alu_CB_in  output  1 to drive the downstream ALU.
REQ-010 SHALL have ports alu_Result  input  n and alu_CB_out  input  1 to return the ALU outputs.
REQ-011 SHALL have port rsp_valid  output  1  to signal that a response is present.
REQ-012 SHALL have port rsp_ready  input  1  to accept the response.
REQ-013 SHALL have port rsp_data  output  n  carrying the accumulator value after the command.
REQ-014 SHALL have ports flag_c and flag_z  output  1 each, as registered carry/borrow and zero flags.

Function
REQ-015 SHALL implement a 3-state FSM: IDLE, EXEC and RESP.
REQ-016 IDLE SHALL drive cmd_ready=1 and SHALL latch cmd_load, cmd_op and cmd_data on cmd_valid&&cmd_ready before moving to EXEC.
REQ-017 EXEC SHALL last exactly 1 cycle and SHALL drive alu_A=ACC, alu_B=latched data, alu_Mode=latched op and alu_CB_in=flag_c.
REQ-018 At the end of EXEC, the block SHALL write ACC: alu_Result for an ALU command, or the latched data for a load command.
REQ-019 At the end of EXEC, flag_z SHALL be set to (new ACC == 0) for every command.
REQ-020 At the end of EXEC, flag_c SHALL take alu_CB_out only for ALU modes 000/001; it SHALL be cleared on load and left unchanged for modes 010-111.
REQ-021 RESP SHALL hold rsp_valid=1 with rsp_data=ACC stable until rsp_ready=1, and SHALL then return to IDLE.
REQ-022 Outside RESP, rsp_valid SHALL be 0; outside IDLE, cmd_ready SHALL be 0, and cmd_valid SHALL be ignored there.
REQ-023 Latency: a command accepted at cycle T SHALL give EXEC at T+1 and rsp_valid at T+2; with rsp_ready held high, throughput SHALL be 1 command per 3 cycles.
REQ-024 The ALU SHALL be treated as combinational: alu_Result and alu_CB_out are sampled in the same EXEC cycle.
REQ-025 Arithmetic SHALL wrap modulo 2^n, with carry/borrow reported only through flag_c.
REQ-026 In IDLE and RESP, alu_* outputs SHALL hold their last values; they are don't-care to the verifier.
REQ-027 rsp_ready asserted outside RESP SHALL have no effect.

Reset
REQ-028 While rst_n=0, state SHALL be IDLE and ACC, flag_c, flag_z, rsp_valid, the latched operands and alu_* SHALL all be 0.
REQ-029 While rst_n=0, cmd_ready SHALL be 0; it SHALL rise in the first cycle after rst_n deasserts.
REQ-030 Reset asserted in EXEC or RESP SHALL abort the command with no response and no ACC update.

Verification (n=4)
REQ-031 Reset release -> ACC=0, flags 0, rsp_valid=0, cmd_ready=1 on the next cycle.
REQ-032 LOAD 0xF, then ADD (op 000) B=0x1 -> rsp_data=0x0, flag_c=1, flag_z=1, rsp_valid at T+2.
REQ-033 ADD B=0x0 immediately after REQ-032 -> alu_CB_in=1, rsp_data=0x1, flag_c=0, flag_z=0.
REQ-034 LOAD 0x3, then SUB B=0x5 -> rsp_data=0xE, flag_c=1; follow with AND B=0x0 -> rsp_data=0x0, flag_z=1, flag_c stays 1.
REQ-035 rsp_ready held low for 3 cycles while cmd_valid=1 -> rsp_valid and rsp_data stable, cmd_ready=0, no second command accepted.
REQ-036 rst_n pulsed low during EXEC of LOAD 0x7 -> ACC=0, no rsp_valid, FSM in IDLE.
